// File: rtl/ikari_video_pkg.sv
// Shared video timing constants and counter type for the Ikari video path.
// Also used by the sprite/tile line buffers.
package ikari_video_pkg;

    localparam int CNT_W = 9;

    localparam int DEF_H_TOTAL      = 424;
    localparam int DEF_H_ACTIVE     = 288;
    localparam int DEF_H_SYNC_START = 320;
    localparam int DEF_H_SYNC_END   = 352;

    localparam int DEF_V_TOTAL      = 262;
    localparam int DEF_V_ACTIVE     = 216;
    localparam int DEF_V_SYNC_START = 232;
    localparam int DEF_V_SYNC_END   = 235;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic in_window(cnt_t c, cnt_t lo, cnt_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/ikari_video_timing.sv
// Raster counters, blanking/sync decode, line strobe and vblank interrupt.
// Every output is registered from the next-state counter values.
module ikari_video_timing
    import ikari_video_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cen_6p7,
    input  logic             i_int_ack,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_line_start,
    output logic             o_vbl_int,
    output logic [7:0]       o_frame
);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
          H_SYNC_END <= H_TOTAL && H_TOTAL <= 512)) begin : g_bad_h
        $error("ikari_video_timing: illegal horizontal timing");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
          V_SYNC_END <= V_TOTAL && V_TOTAL <= 512)) begin : g_bad_v
        $error("ikari_video_timing: illegal vertical timing");
    end

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
    localparam cnt_t H_SS   = cnt_t'(H_SYNC_START);
    localparam cnt_t H_SE   = cnt_t'(H_SYNC_END);
    localparam cnt_t V_SS   = cnt_t'(V_SYNC_START);
    localparam cnt_t V_SE   = cnt_t'(V_SYNC_END);

    cnt_t       h_nxt;
    cnt_t       v_nxt;
    logic [7:0] f_nxt;
    logic       line_nxt;
    logic       irq_set;

    always_comb begin
        h_nxt = o_hcount;
        v_nxt = o_vcount;
        f_nxt = o_frame;
        if (i_cen_6p7) begin
            if (o_hcount == H_LAST) begin
                h_nxt = '0;
                if (o_vcount == V_LAST) begin
                    v_nxt = '0;
                    f_nxt = o_frame + 8'd1;
                end else begin
                    v_nxt = o_vcount + 1'b1;
                end
            end else begin
                h_nxt = o_hcount + 1'b1;
            end
        end
    end

    // A new line begins only on an enabled edge that lands on column 0.
    assign line_nxt = i_cen_6p7 && (h_nxt == '0);
    assign irq_set  = line_nxt && (v_nxt == V_ACT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hcount     <= '0;
            o_vcount     <= '0;
            o_frame      <= '0;
            o_hblank     <= 1'b0;
            o_vblank     <= 1'b0;
            o_hsync_n    <= 1'b1;
            o_vsync_n    <= 1'b1;
            o_line_start <= 1'b0;
            o_vbl_int    <= 1'b0;
        end else begin
            o_line_start <= line_nxt;
            if (irq_set) begin
                o_vbl_int <= 1'b1;
            end else if (i_int_ack) begin
                o_vbl_int <= 1'b0;
            end
            if (i_cen_6p7) begin
                o_hcount  <= h_nxt;
                o_vcount  <= v_nxt;
                o_frame   <= f_nxt;
                o_hblank  <= (h_nxt >= H_ACT);
                o_vblank  <= (v_nxt >= V_ACT);
                o_hsync_n <= !in_window(h_nxt, H_SS, H_SE);
                o_vsync_n <= !in_window(v_nxt, V_SS, V_SE);
            end
        end
    end

endmodule

// File: tb/tb_ikari_video_timing.sv
// Randomized bench: three timing configurations driven in lockstep
// against a pixel-count arithmetic reference model.
module tb_ikari_video_timing;
    import ikari_video_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    logic ack = 1'b0;

    always #5 clk = ~clk;

    int ht [3] = '{424, 40, 4};
    int ha [3] = '{288, 24, 1};
    int hss[3] = '{320, 28, 2};
    int hse[3] = '{352, 32, 3};
    int vt [3] = '{262, 20, 4};
    int va [3] = '{216, 14, 1};
    int vss[3] = '{232, 16, 2};
    int vse[3] = '{235, 18, 4};

    longint pix[3];
    logic   ls [3];
    logic   irq[3];

    int total = 0;
    int bad   = 0;

    logic [8:0] hc[3];
    logic [8:0] vc[3];
    logic       hb[3], vb[3], hs[3], vs[3], lst[3], vi[3];
    logic [7:0] fr[3];
    logic [31:0] obs[3];

    ikari_video_timing u_dflt (
        .i_clk(clk), .i_rst(rst), .i_cen_6p7(cen), .i_int_ack(ack),
        .o_hcount(hc[0]), .o_vcount(vc[0]),
        .o_hblank(hb[0]), .o_vblank(vb[0]),
        .o_hsync_n(hs[0]), .o_vsync_n(vs[0]),
        .o_line_start(lst[0]), .o_vbl_int(vi[0]), .o_frame(fr[0])
    );

    ikari_video_timing #(
        .H_TOTAL(40), .H_ACTIVE(24), .H_SYNC_START(28), .H_SYNC_END(32),
        .V_TOTAL(20), .V_ACTIVE(14), .V_SYNC_START(16), .V_SYNC_END(18)
    ) u_mid (
        .i_clk(clk), .i_rst(rst), .i_cen_6p7(cen), .i_int_ack(ack),
        .o_hcount(hc[1]), .o_vcount(vc[1]),
        .o_hblank(hb[1]), .o_vblank(vb[1]),
        .o_hsync_n(hs[1]), .o_vsync_n(vs[1]),
        .o_line_start(lst[1]), .o_vbl_int(vi[1]), .o_frame(fr[1])
    );

    ikari_video_timing #(
        .H_TOTAL(4), .H_ACTIVE(1), .H_SYNC_START(2), .H_SYNC_END(3),
        .V_TOTAL(4), .V_ACTIVE(1), .V_SYNC_START(2), .V_SYNC_END(4)
    ) u_tiny (
        .i_clk(clk), .i_rst(rst), .i_cen_6p7(cen), .i_int_ack(ack),
        .o_hcount(hc[2]), .o_vcount(vc[2]),
        .o_hblank(hb[2]), .o_vblank(vb[2]),
        .o_hsync_n(hs[2]), .o_vsync_n(vs[2]),
        .o_line_start(lst[2]), .o_vbl_int(vi[2]), .o_frame(fr[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = {hc[g], vc[g], hb[g], vb[g], hs[g], vs[g],
                         lst[g], vi[g], fr[g]};
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Position follows purely from the number of enabled pixels since reset.
    function automatic logic [31:0] expect_of(int i);
        longint h, v, f;
        logic [8:0] h9, v9;
        logic [7:0] f8;
        h  = pix[i] % ht[i];
        v  = (pix[i] / ht[i]) % vt[i];
        f  = (pix[i] / (ht[i] * vt[i])) % 256;
        h9 = 9'(h);
        v9 = 9'(v);
        f8 = 8'(f);
        return {h9, v9, h >= ha[i], v >= va[i],
                !(h >= hss[i] && h < hse[i]),
                !(v >= vss[i] && v < vse[i]),
                ls[i], irq[i], f8};
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                pix[i] = 0;
                ls[i]  = 1'b0;
                irq[i] = 1'b0;
            end else begin
                if (cen) pix[i]++;
                ls[i] = cen && (pix[i] % ht[i] == 0);
                if (ls[i] && ((pix[i] / ht[i]) % vt[i] == va[i]))
                    irq[i] = 1'b1;
                else if (ack)
                    irq[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle(logic r, logic c, logic a);
        string tags[3];
        tags = '{"dflt", "mid", "tiny"};
        @(negedge clk);
        rst = r;
        cen = c;
        ack = a;
        @(posedge clk);
        #1;
        model_step();
        for (int i = 0; i < 3; i++) check(tags[i], obs[i], expect_of(i));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            pix[k] = 0;
            ls[k]  = 1'b0;
            irq[k] = 1'b0;
        end
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b1, 1'b1);
        // Slow pixel rate: one enable every 8 clocks across a full default line.
        for (int n = 0; n < 8 * 440; n++)
            cycle(1'b0, (n % 8) == 7, $urandom_range(0, 99) == 0);
        // Random enable and sparse acks.
        for (int n = 0; n < 20000; n++)
            cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        // Enable held high.
        for (int n = 0; n < 6000; n++)
            cycle(1'b0, 1'b1, $urandom_range(0, 127) == 0);
        // Ack held high: every setting edge collides with an ack.
        for (int n = 0; n < 300; n++)
            cycle(1'b0, 1'b1, 1'b1);
        // No acks for a while: request must hold.
        for (int n = 0; n < 1200; n++)
            cycle(1'b0, $urandom_range(0, 1) == 1, 1'b0);
        // Mid-frame reset with enable high, then resume.
        cycle(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 3000; n++)
            cycle(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
